// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant handshake between the round-robin arbiter and its consumer (the 8:3 encoder).
// master is the arbiter side, slave is the consumer/requester side.
interface rr_onehot_arbiter_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] req;
    logic         grant_ack;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic         timeout;

    modport master (
        input  req,
        input  grant_ack,
        output grant,
        output grant_valid,
        output timeout
    );

    modport slave (
        output req,
        output grant_ack,
        input  grant,
        input  grant_valid,
        input  timeout
    );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: registers one one-hot winner and holds it until acked or until
// the optional hold timer revokes it. Every release is followed by one idle cycle.
module rr_onehot_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_onehot_arbiter_if.master  bus
);

    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned CntW = (MAX_HOLD > 0) ? (($clog2(MAX_HOLD + 1) > 0) ?
                                   $clog2(MAX_HOLD + 1) : 1) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);
    localparam bit TimeoutEn = (MAX_HOLD != 0);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] winner_q, winner_d;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            timeout_q, timeout_d;

    logic            found;
    logic [IdxW-1:0] idx;
    logic [IdxW-1:0] win_idx;
    logic [N-1:0]    win_onehot;

    // Scan ptr, ptr+1, ... with natural IdxW-bit wrap; relies on N being a power of two.
    always_comb begin
        found      = 1'b0;
        idx        = '0;
        win_idx    = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ptr_q + IdxW'(i);
            if (!found && bus.req[idx]) begin
                found           = 1'b1;
                win_idx         = idx;
                win_onehot[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d    = StGrant;
                    winner_d   = win_idx;
                    grant_d    = win_onehot;
                    hold_cnt_d = '0;
                end
            end
            StGrant: begin
                // Ack takes priority over an expiring hold timer.
                if (bus.grant_ack) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = winner_q + IdxW'(1);
                end else if (TimeoutEn && (hold_cnt_q == HoldLast)) begin
                    state_d   = StIdle;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    ptr_d     = winner_q + IdxW'(1);
                end else if (TimeoutEn) begin
                    hold_cnt_d = hold_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            winner_q   <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.timeout     = timeout_q;

endmodule
